bbfifo_param: RTL

Parametrised synchronous FIFO that succeeds the fixed 16x8 UART buffer. It combines the storage array, pointer control and status into one block. Data width and depth are set per instance, and the block adds a level count, programmable almost-full and almost-empty thresholds, sticky overflow and underflow flags, and a synchronous flush. It sits between the UART byte engines (rx shift/tx shift) and the register/bus interface, one instance per direction.

---
 rtl/bbfifo_pkg.sv | 21 ++
 rtl/bbfifo_param_mem.sv | 35 +++
 rtl/bbfifo_param.sv | 115 +++++++++++
 3 files changed

// File: rtl/bbfifo_pkg.sv
// Shared constants and helpers for the parametrised UART byte FIFO family.
// Default geometry matches the UART rx/tx buffer instances.
package bbfifo_pkg;

  localparam int UART_WIDTH = 8;
  localparam int UART_DEPTH = 16;

  // Ceiling log2 for constant elaboration; returns 1 for value == 2.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bbfifo_param_mem.sv
// WIDTH x DEPTH register array: async-cleared, one write port, combinational
// read mux. Successor of the fixed 16x8 UART buffer memory.
module bbfifo_param_mem
  import bbfifo_pkg::*;
#(
  parameter int  WIDTH = UART_WIDTH,
  parameter int  DEPTH = UART_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the array is cleared on reset so rd_data reads 0 from an empty
  // FIFO; this forces flops rather than RAM macros, acceptable at these depths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/bbfifo_param.sv
// Parametrised first-word-fall-through FIFO with level count, almost
// thresholds, sticky overflow/underflow flags and synchronous flush.
module bbfifo_param
  import bbfifo_pkg::*;
#(
  parameter int  WIDTH    = UART_WIDTH,
  parameter int  DEPTH    = UART_DEPTH,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [AW:0]      level_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clr_flags_i
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AF   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] LVL_AE   = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_empty;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_level_next;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);

  // Flush suppresses the write so storage stays untouched that cycle.
  assign w_wr_ok = wr_en_i & ~w_full & ~flush_i;
  assign w_rd_ok = rd_en_i & ~w_empty;

  // NOTE: every path assigns w_level_next via the leading default, so no
  // latch is inferred even though the case has no-change arms.
  always_comb begin
    w_level_next = r_level;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_level_next = r_level + LVL_ONE;
      2'b01:   w_level_next = r_level - LVL_ONE;
      default: w_level_next = r_level;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_level <= w_level_next;

      // Setting a sticky flag wins over a same-cycle clear.
      if (wr_en_i && w_full)  r_overflow <= 1'b1;
      else if (clr_flags_i)   r_overflow <= 1'b0;

      if (rd_en_i && w_empty) r_underflow <= 1'b1;
      else if (clr_flags_i)   r_underflow <= 1'b0;
    end
  end

  bbfifo_param_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data_i),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rd_data_o)
  );

  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign almost_full_o  = (r_level >= LVL_AF);
  assign almost_empty_o = (r_level <= LVL_AE);
  assign level_o        = r_level;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule
